bispectrum_triple_feeder: RTL
=============================

Name: bispectrum_triple_feeder

Overview:
- Producer side of the bispectrum triple-product interface.
- Walks the principal bispectrum domain of one stored FFT frame and reads each bin from a synchronous spectrum RAM.
- Presents each triple (F1=X[k1], F2=X[k2], F3=X[k1+k2]) with a valid/ready handshake to the triple-product engine and its segment accumulator.
- One pass per start pulse; F3 is passed un-conjugated, because conjugation belongs to the consumer.

Parameters:
- DATA_W, 16, width of each real/imag bin component (signed, fixed point, passed through untouched).
- N_LOG2, 8, log2 of FFT size N; legal range 3..12.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse; begins a pass when idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last triple handshakes.
- rd_en  out  1  spectrum RAM read strobe.
- rd_addr  out  N_LOG2  bin index to read.
- rd_data_r  in  DATA_W  RAM real output, valid 1 cycle after rd_en.
- rd_data_i  in  DATA_W  RAM imag output, valid 1 cycle after rd_en.
- out_valid  out  1  triple valid.
- out_ready  in  1  consumer accepts.
- f1_r, f1_i, f2_r, f2_i, f3_r, f3_i  out  DATA_W each  bin values.
- k1, k2  out  N_LOG2 each  indices of the current triple.
- out_last  out  1  high with the final triple of the pass.

Behaviour:
- Reset (sync, rst=1): state IDLE; all outputs 0, including busy, done, rd_en, rd_addr, out_valid, out_last, all f*, k1, k2. Reset mid-pass abandons the pass: no done pulse, no partial output.
- Domain, with H=N/2: 0<=k2<=k1 and k1+k2<H, so k1+k2 never exceeds H-1. Order: k1 outer ascending, k2 inner ascending. Total triples = sum over k1 of min(k1, H-1-k1)+1. N=8 gives 6: (0,0),(1,0),(1,1),(2,0),(2,1),(3,0).
- FSM states: IDLE, RD1, RD2, RD3, CAP, OUT, FIN.
  - IDLE: start=1 -> k1=0, k2=0, busy=1, go RD1. start while not IDLE is ignored.
  - RD1: rd_en=1, rd_addr=k1 -> RD2.
  - RD2: rd_en=1, rd_addr=k2; capture rd_data as F1 -> RD3.
  - RD3: rd_en=1, rd_addr=k1+k2; capture F2 -> CAP.
  - CAP: rd_en=0; capture F3 -> OUT.
  - OUT: out_valid=1. f*, k1, k2 and out_last are held stable until out_valid&&out_ready. On handshake, out_valid drops the next cycle.
    - If not last: advance indices, go RD1.
    - If last: go FIN.
  - FIN: done=1 for one cycle, busy=0 -> IDLE.
- rd_en is 0 in all states other than RD1-RD3.
- k1==k2 still issues a separate read; no read is skipped.
- Index advance: if k2+1<=k1 and k1+k2+1<H, then k2++. Otherwise k1++ and k2=0. Last triple is the one whose advance would give k1==H.
- out_last = 1 exactly when the current triple is last.
- Throughput with out_ready held high: one triple per 5 cycles. First out_valid appears 5 cycles after the start cycle.
- Address arithmetic: k1+k2 is computed N_LOG2 wide; it cannot wrap because k1+k2<H.
- No arithmetic on data; values pass through bit-exact.

Optional Feature:
- Macro BISPEC_FEED_SKIP_DC_EN.
- Defined: domain additionally requires k2>=1. The pass starts at k1=1, k2=1, and the advance resets k2 to 1 instead of 0.
  - If H<=2 the domain is empty: the pass goes straight to FIN, done pulses, and no out_valid is ever asserted.
  - N=8 yields (1,1),(2,1).
- Undefined: full domain as specified above.

Test Plan:
- N_LOG2=3; RAM bin b = (100+b, -b); out_ready=1; pulse start -> exactly 6 triples in the listed order. Triple (2,1) must be f1=(102,-2), f2=(101,-1), f3=(103,-3). out_last only on (3,0); done 1 cycle after its handshake; first out_valid 5 cycles after start.
- Backpressure: out_ready low for 7 cycles during triple (1,1) -> out_valid and data stay stable, no rd_en toggles, then the sequence resumes unchanged.
- N_LOG2=4 full pass -> 20 triples, max rd_addr=7, busy high throughout, done pulses once.
- rst=1 for one cycle while in RD3 of triple (2,0) -> all outputs 0 next cycle, no done. A new start then restarts at (0,0).
- start pulsed again mid-pass -> ignored; total triple count unchanged.
- BISPEC_FEED_SKIP_DC_EN, N_LOG2=3 -> only (1,1),(2,1) emitted, out_last on (2,1).

Source files
------------

// File: rtl/bispectrum_triple_feeder.sv
// Bispectrum triple feeder: walks the principal domain of one stored FFT frame
// and streams (X[k1], X[k2], X[k1+k2]) triples. Optional macro: BISPEC_FEED_SKIP_DC_EN.
module bispectrum_triple_feeder #(
   parameter int DATA_W = 16,
   parameter int N_LOG2 = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              rd_en,
   output logic [N_LOG2-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data_r,
   input  logic [DATA_W-1:0] rd_data_i,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] f1_r,
   output logic [DATA_W-1:0] f1_i,
   output logic [DATA_W-1:0] f2_r,
   output logic [DATA_W-1:0] f2_i,
   output logic [DATA_W-1:0] f3_r,
   output logic [DATA_W-1:0] f3_i,
   output logic [N_LOG2-1:0] k1,
   output logic [N_LOG2-1:0] k2,
   output logic              out_last,
   output logic [2:0]        dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD1  = 3'd1,
      S_RD2  = 3'd2,
      S_RD3  = 3'd3,
      S_CAP  = 3'd4,
      S_OUT  = 3'd5,
      S_FIN  = 3'd6
   } state_t;

   // One extra bit so index sums and the H comparisons can never wrap.
   localparam int KW = N_LOG2 + 1;
   localparam logic [KW-1:0] H = KW'(1) << (N_LOG2 - 1);

`ifdef BISPEC_FEED_SKIP_DC_EN
   localparam logic [N_LOG2-1:0] K_MIN = N_LOG2'(1);
   localparam logic              EMPTY = (H <= KW'(2));
`else
   localparam logic [N_LOG2-1:0] K_MIN = '0;
   localparam logic              EMPTY = 1'b0;
`endif

   state_t              r_state;
   logic                r_busy, r_done, r_rd_en, r_valid, r_last;
   logic [N_LOG2-1:0]   r_rd_addr, r_k1, r_k2;
   logic [DATA_W-1:0]   r_f1_r, r_f1_i, r_f2_r, r_f2_i, r_f3_r, r_f3_i;

   logic [KW-1:0]       w_k1x, w_k2x;
   logic                w_inc_k2, w_last;
   logic [N_LOG2-1:0]   w_sum, w_nk1, w_nk2;

   assign w_k1x    = {1'b0, r_k1};
   assign w_k2x    = {1'b0, r_k2};
   assign w_inc_k2 = (w_k2x + KW'(1) <= w_k1x) && (w_k1x + w_k2x + KW'(1) < H);
   // Last when the next k1 row would hold no legal (k1, K_MIN) point.
   assign w_last   = !w_inc_k2 && (w_k1x + KW'(1) + {1'b0, K_MIN} >= H);
   assign w_sum    = r_k1 + r_k2;
   assign w_nk1    = w_inc_k2 ? r_k1 : r_k1 + N_LOG2'(1);
   assign w_nk2    = w_inc_k2 ? r_k2 + N_LOG2'(1) : K_MIN;

   // Handshake: a triple transfers on a rising edge where out_valid && out_ready;
   // while out_valid is high and out_ready low every triple output holds steady.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_rd_en   <= 1'b0;
         r_rd_addr <= '0;
         r_valid   <= 1'b0;
         r_last    <= 1'b0;
         r_k1      <= '0;
         r_k2      <= '0;
         r_f1_r    <= '0;
         r_f1_i    <= '0;
         r_f2_r    <= '0;
         r_f2_i    <= '0;
         r_f3_r    <= '0;
         r_f3_i    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (EMPTY) begin
                     r_done  <= 1'b1;
                     r_state <= S_FIN;
                  end else begin
                     r_k1      <= K_MIN;
                     r_k2      <= K_MIN;
                     r_busy    <= 1'b1;
                     r_rd_en   <= 1'b1;
                     r_rd_addr <= K_MIN;
                     r_state   <= S_RD1;
                  end
               end
            end
            S_RD1: begin
               r_rd_addr <= r_k2;
               r_state   <= S_RD2;
            end
            S_RD2: begin
               r_f1_r    <= rd_data_r;
               r_f1_i    <= rd_data_i;
               r_rd_addr <= w_sum;
               r_state   <= S_RD3;
            end
            S_RD3: begin
               r_f2_r  <= rd_data_r;
               r_f2_i  <= rd_data_i;
               r_rd_en <= 1'b0;
               r_state <= S_CAP;
            end
            S_CAP: begin
               r_f3_r  <= rd_data_r;
               r_f3_i  <= rd_data_i;
               r_valid <= 1'b1;
               r_last  <= w_last;
               r_state <= S_OUT;
            end
            S_OUT: begin
               if (out_ready) begin
                  r_valid <= 1'b0;
                  r_last  <= 1'b0;
                  if (r_last) begin
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_FIN;
                  end else begin
                     r_k1      <= w_nk1;
                     r_k2      <= w_nk2;
                     r_rd_en   <= 1'b1;
                     r_rd_addr <= w_nk1;
                     r_state   <= S_RD1;
                  end
               end
            end
            S_FIN: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy      = r_busy;
   assign done      = r_done;
   assign rd_en     = r_rd_en;
   assign rd_addr   = r_rd_addr;
   assign out_valid = r_valid;
   assign out_last  = r_last;
   assign k1        = r_k1;
   assign k2        = r_k2;
   assign f1_r      = r_f1_r;
   assign f1_i      = r_f1_i;
   assign f2_r      = r_f2_r;
   assign f2_i      = r_f2_i;
   assign f3_r      = r_f3_r;
   assign f3_i      = r_f3_i;
   assign dbg_state = r_state;

endmodule
